// File: rtl/clock_period_meter.sv
// Measures period (rise to rise) and high time (rise to fall) of a slow asynchronous
// square wave in cycles of clkOld, with a stall flag when rising edges stop arriving.
module clock_period_meter #(
    parameter int unsigned WIDTH   = 21,
    parameter int unsigned TIMEOUT = 2000000
) (
    input  logic             clkOld,
    input  logic             rst,
    input  logic             sigIn,
    output logic [WIDTH-1:0] periodOut,
    output logic [WIDTH-1:0] highOut,
    output logic             periodValid,
    output logic             highValid,
    output logic             stalled
);

    localparam logic [WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [WIDTH-1:0] CNT_ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_CNT = WIDTH'(TIMEOUT);

    logic             s1;
    logic             s2;
    logic             prev;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] pcnt;
    logic [WIDTH-1:0] hcnt;
    logic             armed;
    logic             high_armed;

    always_comb begin
        rise = s2 & ~prev;
        fall = ~s2 & prev;
    end

    always_ff @(posedge clkOld or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= sigIn;
            s2   <= s1;
            prev <= s2;
        end
    end

    // A rise always takes priority over the timeout check, so a period of exactly
    // TIMEOUT cycles is still reported rather than flagged as a stall.
    always_ff @(posedge clkOld or negedge rst) begin
        if (!rst) begin
            pcnt        <= '0;
            hcnt        <= '0;
            armed       <= 1'b0;
            high_armed  <= 1'b0;
            periodOut   <= '0;
            highOut     <= '0;
            periodValid <= 1'b0;
            highValid   <= 1'b0;
            stalled     <= 1'b0;
        end else begin
            periodValid <= 1'b0;
            highValid   <= 1'b0;
            if (rise) begin
                pcnt       <= CNT_ONE;
                hcnt       <= CNT_ONE;
                armed      <= 1'b1;
                high_armed <= 1'b1;
                stalled    <= 1'b0;
                if (armed) begin
                    periodOut   <= pcnt;
                    periodValid <= 1'b1;
                end
            end else begin
                if (pcnt != CNT_MAX) begin
                    pcnt <= pcnt + CNT_ONE;
                end
                if (s2 && (hcnt != CNT_MAX)) begin
                    hcnt <= hcnt + CNT_ONE;
                end
                if (fall && high_armed) begin
                    highOut    <= hcnt;
                    highValid  <= 1'b1;
                    high_armed <= 1'b0;
                end
                if (pcnt == TIMEOUT_CNT) begin
                    stalled    <= 1'b1;
                    armed      <= 1'b0;
                    high_armed <= 1'b0;
                end
            end
        end
    end

endmodule
